pipe_stage_reg: RTL and testbench



---
 rtl/pipe_stage_reg_if.sv | 32 +++
 rtl/pipe_stage_reg.sv | 115 +++++++++++
 tb/tb_pipe_stage_reg.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module : pipe_stage_reg_if
// Brief  : Upstream/downstream handshake, flush and stall-counter bundle.
// Rev    : 1.0
// ============================================================================
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 97,
  parameter int unsigned CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic              cnt_clr;
  logic [CNT_W-1:0]  stall_cnt;

  // The environment surrounding the stage (upstream producer + downstream consumer).
  modport master (
    output in_valid, in_data, out_ready, flush, cnt_clr,
    input  in_ready, out_valid, out_data, stall_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush, cnt_clr,
    output in_ready, out_valid, out_data, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module : pipe_stage_reg
// Brief  : Elastic pipeline register, valid/ready with 2-entry skid buffer,
//          flush-to-bubble and a saturating back-pressure counter.
// Rev    : 1.0
// ============================================================================
module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 97,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {{(DATA_W-32){1'b0}}, 32'h00000013},
  parameter int unsigned       CNT_W      = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  pipe_stage_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL  = 2'd1,
    S_SKID  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic out_valid;
  logic acc;
  logic pop;

  assign out_valid     = (state_q != S_EMPTY);
  assign bus.out_valid = out_valid;
  // main_q is forced to BUBBLE_VAL whenever the stage empties, so out_data stays registered.
  assign bus.out_data  = main_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.stall_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    cnt_d   = cnt_q;
    acc     = bus.in_valid & in_ready_q;
    pop     = out_valid & bus.out_ready;

    if (bus.flush) begin
      state_d = S_EMPTY;
      main_d  = BUBBLE_VAL;
      skid_d  = BUBBLE_VAL;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (acc) begin
            state_d = S_FULL;
            main_d  = bus.in_data;
          end
        end
        S_FULL: begin
          if (acc && pop) begin
            main_d = bus.in_data;
          end else if (acc) begin
            state_d = S_SKID;
            skid_d  = bus.in_data;
          end else if (pop) begin
            state_d = S_EMPTY;
            main_d  = BUBBLE_VAL;
          end
        end
        S_SKID: begin
          if (pop) begin
            state_d = S_FULL;
            main_d  = skid_q;
            skid_d  = BUBBLE_VAL;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = BUBBLE_VAL;
          skid_d  = BUBBLE_VAL;
        end
      endcase
    end

    in_ready_d = (state_d != S_SKID);

    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (out_valid && !bus.out_ready && (cnt_q != C_CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_EMPTY;
      main_q     <= BUBBLE_VAL;
      skid_q     <= BUBBLE_VAL;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_stage_reg
// Brief  : Directed scenarios plus randomized traffic against a 2-deep FIFO model.
// Rev    : 1.0
// ============================================================================
module tb_pipe_stage_reg;

  localparam int unsigned      DW  = 97;
  localparam logic [DW-1:0]    BUB = {{(DW-32){1'b0}}, 32'h00000013};

  logic clk = 1'b0;
  logic reset_n;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.DATA_W(DW), .CNT_W(16)) bus  ();
  pipe_stage_reg_if #(.DATA_W(DW), .CNT_W(3))  bus3 ();

  pipe_stage_reg #(.DATA_W(DW), .BUBBLE_VAL(BUB), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave));

  pipe_stage_reg #(.DATA_W(DW), .BUBBLE_VAL(BUB), .CNT_W(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3.slave));

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit ordy,
                       input bit fl, input bit clr);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
    bus.cnt_clr   = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, '0, 0, 0, 0);
    #1 reset_n = 1'b0;
    #1;
    nvec += 4;
    if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
    if (bus.out_data !== BUB) begin nerr++; $display("FAIL reset out_data: got %h want %h", bus.out_data, BUB); end
    if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL reset in_ready: got %b want 1", bus.in_ready); end
    if (bus.stall_cnt !== 16'd0) begin nerr++; $display("FAIL reset stall_cnt: got %0d want 0", bus.stall_cnt); end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      drive(1, DW'(i), 1, 0, 0);
      tick();
      nvec += 3;
      if (bus.out_valid !== 1'b1) begin nerr++; $display("FAIL stream valid[%0d]: got %b want 1", i, bus.out_valid); end
      if (bus.out_data !== DW'(i)) begin nerr++; $display("FAIL stream data[%0d]: got %h want %h", i, bus.out_data, DW'(i)); end
      if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL stream in_ready[%0d]: got %b want 1", i, bus.in_ready); end
    end
    drive(0, '0, 1, 0, 0);
    tick();
    nvec += 3;
    if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL stream drain valid: got %b want 0", bus.out_valid); end
    if (bus.out_data !== BUB) begin nerr++; $display("FAIL stream drain data: got %h want %h", bus.out_data, BUB); end
    if (bus.stall_cnt !== 16'd0) begin nerr++; $display("FAIL stream stall_cnt: got %0d want 0", bus.stall_cnt); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a = DW'(97'h1_AAAA_0000_1111_2222_3333);
    logic [DW-1:0] b = DW'(97'h0_BBBB_4444_5555_6666_7777);
    drive(1, a, 0, 0, 0);
    tick();
    nvec += 3;
    if (bus.out_data !== a) begin nerr++; $display("FAIL bp A head: got %h want %h", bus.out_data, a); end
    if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL bp ready after A: got %b want 1", bus.in_ready); end
    if (bus.stall_cnt !== 16'd0) begin nerr++; $display("FAIL bp cnt after A: got %0d want 0", bus.stall_cnt); end
    drive(1, b, 0, 0, 0);
    tick();
    nvec += 3;
    if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL bp ready after B: got %b want 0", bus.in_ready); end
    if (bus.out_data !== a) begin nerr++; $display("FAIL bp hold A: got %h want %h", bus.out_data, a); end
    if (bus.stall_cnt !== 16'd1) begin nerr++; $display("FAIL bp cnt after B: got %0d want 1", bus.stall_cnt); end
    drive(0, '0, 0, 0, 0);
    tick();
    nvec += 2;
    if (bus.out_data !== a) begin nerr++; $display("FAIL bp stall A: got %h want %h", bus.out_data, a); end
    if (bus.stall_cnt !== 16'd2) begin nerr++; $display("FAIL bp cnt stall: got %0d want 2", bus.stall_cnt); end
    drive(0, '0, 1, 0, 0);
    tick();
    nvec += 4;
    if (bus.out_valid !== 1'b1) begin nerr++; $display("FAIL bp B valid: got %b want 1", bus.out_valid); end
    if (bus.out_data !== b) begin nerr++; $display("FAIL bp B head: got %h want %h", bus.out_data, b); end
    if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL bp ready after pop: got %b want 1", bus.in_ready); end
    if (bus.stall_cnt !== 16'd2) begin nerr++; $display("FAIL bp cnt on pop: got %0d want 2", bus.stall_cnt); end
    tick();
    nvec += 1;
    if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL bp drained: got %b want 0", bus.out_valid); end
    drive(0, '0, 1, 0, 1);
    tick();
    nvec += 1;
    if (bus.stall_cnt !== 16'd0) begin nerr++; $display("FAIL bp cnt_clr: got %0d want 0", bus.stall_cnt); end
  endtask

  task automatic test_flush_skid();
    drive(1, DW'(32'hA), 0, 0, 0);
    tick();
    drive(1, DW'(32'hB), 0, 0, 0);
    tick();
    drive(1, DW'(32'hC), 0, 1, 0);
    tick();
    nvec += 3;
    if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL flush_skid valid: got %b want 0", bus.out_valid); end
    if (bus.out_data !== BUB) begin nerr++; $display("FAIL flush_skid data: got %h want %h", bus.out_data, BUB); end
    if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL flush_skid in_ready: got %b want 1", bus.in_ready); end
    drive(0, '0, 1, 0, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      nvec += 1;
      if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL flush_skid ghost[%0d]: got valid=%b data=%h want 0", i, bus.out_valid, bus.out_data); end
    end
  endtask

  task automatic test_flush_pop();
    drive(1, DW'(32'hA5), 1, 0, 0);
    tick();
    drive(0, '0, 1, 1, 0);
    tick();
    nvec += 2;
    if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL flush_pop valid: got %b want 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL flush_pop in_ready: got %b want 1", bus.in_ready); end
    drive(1, DW'(32'hD), 1, 0, 0);
    tick();
    nvec += 2;
    if (bus.out_valid !== 1'b1) begin nerr++; $display("FAIL flush_pop D valid: got %b want 1", bus.out_valid); end
    if (bus.out_data !== DW'(32'hD)) begin nerr++; $display("FAIL flush_pop D data: got %h want d", bus.out_data); end
    drive(0, '0, 1, 0, 0);
    tick();
  endtask

  task automatic test_async_reset();
    drive(1, DW'(32'h11), 0, 0, 0);
    tick();
    drive(1, DW'(32'h22), 0, 0, 0);
    tick();
    drive(0, '0, 0, 0, 0);
    tick();
    #2 reset_n = 1'b0;
    #1;
    nvec += 4;
    if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL areset out_valid: got %b want 0", bus.out_valid); end
    if (bus.out_data[31:0] !== 32'h00000013) begin nerr++; $display("FAIL areset out_data: got %h want 00000013", bus.out_data[31:0]); end
    if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL areset in_ready: got %b want 1", bus.in_ready); end
    if (bus.stall_cnt !== 16'd0) begin nerr++; $display("FAIL areset stall_cnt: got %0d want 0", bus.stall_cnt); end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic test_counter_sat();
    int exp;
    bus3.in_valid = 1'b1; bus3.in_data = DW'(32'h77); bus3.out_ready = 1'b0;
    tick();
    bus3.in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp = (k > 7) ? 7 : k;
      nvec += 1;
      if (bus3.stall_cnt !== 3'(exp)) begin nerr++; $display("FAIL sat cnt[%0d]: got %0d want %0d", k, bus3.stall_cnt, exp); end
    end
    bus3.cnt_clr = 1'b1;
    tick();
    nvec += 1;
    if (bus3.stall_cnt !== 3'd0) begin nerr++; $display("FAIL sat clr: got %0d want 0", bus3.stall_cnt); end
    bus3.cnt_clr = 1'b0;
    tick();
    nvec += 1;
    if (bus3.stall_cnt !== 3'd1) begin nerr++; $display("FAIL sat after clr: got %0d want 1", bus3.stall_cnt); end
  endtask

  // Reference: the stage is a 2-deep FIFO; ready while it has room, head shown when non-empty.
  task automatic test_random();
    logic [DW-1:0] mq[$];
    int unsigned   mcnt;
    logic [127:0]  r;
    bit            m_valid, m_ready;
    logic [DW-1:0] e_data;
    drive(0, '0, 0, 0, 0);
    #1 reset_n = 1'b0;
    #1 reset_n = 1'b1;
    mq.delete();
    mcnt = 0;
    for (int i = 0; i < 400; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom()};
      drive($urandom_range(9) < 7, r[DW-1:0], $urandom_range(9) < 6,
            $urandom_range(19) == 0, $urandom_range(29) == 0);
      m_valid = (mq.size() > 0);
      m_ready = (mq.size() < 2);
      tick();
      if (bus.cnt_clr) mcnt = 0;
      else if (m_valid && !bus.out_ready && mcnt < 65535) mcnt++;
      if (bus.flush) mq.delete();
      else begin
        if (m_valid && bus.out_ready) void'(mq.pop_front());
        if (bus.in_valid && m_ready) mq.push_back(bus.in_data);
      end
      e_data = (mq.size() > 0) ? mq[0] : BUB;
      nvec += 4;
      if (bus.out_valid !== (mq.size() > 0)) begin nerr++; $display("FAIL rand valid[%0d]: got %b want %b", i, bus.out_valid, mq.size() > 0); end
      if (bus.out_data !== e_data) begin nerr++; $display("FAIL rand data[%0d]: got %h want %h", i, bus.out_data, e_data); end
      if (bus.in_ready !== (mq.size() < 2)) begin nerr++; $display("FAIL rand in_ready[%0d]: got %b want %b", i, bus.in_ready, mq.size() < 2); end
      if (bus.stall_cnt !== 16'(mcnt)) begin nerr++; $display("FAIL rand stall_cnt[%0d]: got %0d want %0d", i, bus.stall_cnt, mcnt); end
    end
  endtask

  initial begin
    reset_n = 1'b1;
    drive(0, '0, 0, 0, 0);
    bus3.in_valid = 1'b0; bus3.in_data = '0; bus3.out_ready = 1'b0;
    bus3.flush = 1'b0; bus3.cnt_clr = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_skid();
    test_flush_pop();
    test_async_reset();
    test_counter_sat();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
